// File: rtl/comparador_mayor_d_i_pkg.sv
// Purpose: shared bit-level comparison function for the magnitude comparator cells.
// Contents: gt_bit(a, b, x) returns "A > B over the bits seen so far" after one more bit.
package comparador_mayor_d_i_pkg;

    // The current bit decides if it differs; otherwise the incoming state carries.
    function automatic logic gt_bit(input logic a, input logic b, input logic x);
        return (a & ~b) | (~(a ^ b) & x);
    endfunction

endpackage

// File: rtl/comparador_mayor_d_i_celdas.sv
// Purpose: combinational cells of the LSB-to-MSB iterative comparator chain.
// Ports (all cells): a_p, b_p = operand bits; x_p = incoming state; p_x = outgoing state.

// Initial cell (bit 0): no incoming state.
module celda_inicial_d_i
    import comparador_mayor_d_i_pkg::*;
(
    input  logic a_p,
    input  logic b_p,
    output logic p_x
);
    assign p_x = gt_bit(a_p, b_p, 1'b0);
endmodule

// Typical cell (bits 1..WIDTH-2).
module celda_tipica_d_i
    import comparador_mayor_d_i_pkg::*;
(
    input  logic a_p,
    input  logic b_p,
    input  logic x_p,
    output logic p_x
);
    assign p_x = gt_bit(a_p, b_p, x_p);
endmodule

// Final cell (bit WIDTH-1): its output is the comparison result.
module celda_final_d_i
    import comparador_mayor_d_i_pkg::*;
(
    input  logic a_p,
    input  logic b_p,
    input  logic x_p,
    output logic p_x
);
    assign p_x = gt_bit(a_p, b_p, x_p);
endmodule

// File: rtl/comparador_mayor_d_i.sv
// Purpose: registered unsigned magnitude comparator, Z = (A > B), 1-cycle latency.
// Ports:
//   clk       - clock, rising edge
//   reset_L   - asynchronous active-low reset
//   valid_in  - A/B qualify this cycle
//   A, B      - unsigned operands, WIDTH bits
//   valid_out - 1-cycle pulse marking a new result on Z
//   Z         - 1 when A > B, held between results
module comparador_mayor_d_i #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             valid_out,
    output logic             Z
);

    logic [WIDTH-1:0] a_qual;
    logic [WIDTH-1:0] b_qual;
    logic [WIDTH-2:0] estado;
    logic             z_comb;
    logic             z_d;
    logic             z_q;
    logic             valid_d;
    logic             valid_q;

    // Operands are gated to zero when not qualified so unknowns never enter the chain.
    assign a_qual = valid_in ? A : '0;
    assign b_qual = valid_in ? B : '0;

    celda_inicial_d_i u_inicial (
        .a_p (a_qual[0]),
        .b_p (b_qual[0]),
        .p_x (estado[0])
    );

    for (genvar i = 1; i <= int'(WIDTH) - 2; i++) begin : g_tipica
        celda_tipica_d_i u_tipica (
            .a_p (a_qual[i]),
            .b_p (b_qual[i]),
            .x_p (estado[i-1]),
            .p_x (estado[i])
        );
    end

    celda_final_d_i u_final (
        .a_p (a_qual[WIDTH-1]),
        .b_p (b_qual[WIDTH-1]),
        .x_p (estado[WIDTH-2]),
        .p_x (z_comb)
    );

    // Result capture: Z only updates on an accepted input.
    always_comb begin
        z_d     = z_q;
        valid_d = 1'b0;
        if (valid_in) begin
            z_d     = z_comb;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            z_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            z_q     <= z_d;
            valid_q <= valid_d;
        end
    end

    assign Z         = z_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_comparador_mayor_d_i.sv
module tb_comparador_mayor_d_i;

    localparam int unsigned W = 5;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         exp_z;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_L = 1'b0;
    logic         valid_in = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         valid_out;
    logic         Z;

    int unsigned  n_checks = 0;
    int unsigned  n_pass = 0;
    logic         sb_q[$];
    logic         held_z = 1'b0;
    logic         vin_s;
    logic         exp_z;

    comparador_mayor_d_i #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .valid_in  (valid_in),
        .A         (A),
        .B         (B),
        .valid_out (valid_out),
        .Z         (Z)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
    endtask

    // Drive one cycle of stimulus at the falling edge; accepted inputs feed the scoreboard.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        valid_in = v;
        A = v ? a : 'x;
        B = v ? b : 'x;
        if (v && reset_L) sb_q.push_back(a > b);
    endtask

    // Output monitor: valid_out must track accepted inputs, Z must match popped results or hold.
    always @(posedge clk) begin
        vin_s = valid_in & reset_L;
        #1;
        if (!reset_L) begin
            held_z = 1'b0;
            check("reset_valid_out", valid_out, 1'b0);
            check("reset_z", Z, 1'b0);
        end else if (vin_s) begin
            check("valid_out_pulse", valid_out, 1'b1);
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty: result with no expected value (t=%0t)", $time);
            end else begin
                exp_z = sb_q.pop_front();
                check("z_result", Z, exp_z);
                held_z = exp_z;
            end
        end else begin
            check("idle_valid_out", valid_out, 1'b0);
            check("z_hold", Z, held_z);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{5'b10000, 5'b01111, 1'b1};
        vecs[1] = '{5'b10101, 5'b10101, 1'b0};
        vecs[2] = '{5'd0,     5'd0,     1'b0};
        vecs[3] = '{5'd31,    5'd31,    1'b0};
        vecs[4] = '{5'b00001, 5'd0,     1'b1};
        vecs[5] = '{5'd0,     5'b00001, 1'b0};
        vecs[6] = '{5'd31,    5'd0,     1'b1};
        vecs[7] = '{5'd0,     5'd31,    1'b0};
        vecs[8] = '{5'd12,    5'd11,    1'b1};

        // Reset held for two edges while inputs toggle.
        @(negedge clk); valid_in = 1'b1; A = 5'd31; B = 5'd0;
        @(negedge clk); valid_in = 1'b0; A = 5'd3;  B = 5'd7;
        @(negedge clk); valid_in = 1'b1; A = 5'd20; B = 5'd1;
        reset_L = 1'b1;
        valid_in = 1'b0;

        // Directed table, applied back to back.
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (vecs[i].exp_z === (vecs[i].a > vecs[i].b)) n_pass++;
            else $display("FAIL table_entry_%0d: table says %b, A>B gives %b",
                          i, vecs[i].exp_z, vecs[i].a > vecs[i].b);
            sb_q.push_back(vecs[i].exp_z);
            @(negedge clk);
            valid_in = 1'b1;
            A = vecs[i].a;
            B = vecs[i].b;
        end
        // Idle: Z must hold the last result (1) with valid_out low.
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);

        // Exhaustive sweep.
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                drive(1'b1, W'(a), W'(b));
        drive(1'b0, '0, '0);

        // Reset pulse between two valid inputs, with a pending input discarded.
        drive(1'b1, 5'd31, 5'd0);
        drive(1'b1, 5'd5, 5'd3);
        #2;
        reset_L = 1'b0;
        sb_q.delete();
        #1;
        check("async_reset_z", Z, 1'b0);
        check("async_reset_valid_out", valid_out, 1'b0);
        drive(1'b0, '0, '0);
        @(negedge clk);
        reset_L = 1'b1;
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        drive(1'b1, 5'd9, 5'd8);
        drive(1'b1, 5'd8, 5'd9);
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        @(negedge clk);

        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
